// File: rtl/ysyx_23060075_idu.sv
// ============================================================================
// Module      : ysyx_23060075_idu
// Description : Instruction decode stage. Accepts a fetched instruction over
//               a valid/ready handshake, decodes RV32I + Zicsr/privileged
//               subset into a registered bundle, and presents it downstream
//               over a second valid/ready handshake.
//               Optional feature macro: YSYX_23060075_ILLEGAL_TRAP_EN
//               (defined: unsupported encodings raise ill_inst and trap via
//               mtvec; undefined: they decode as a nop).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ysyx_23060075_idu #(
    parameter int XLEN      = 32,
    parameter int RF_ADDR_W = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 valid_1,
    output logic                 ready_1,
    output logic                 valid_2,
    input  logic                 ready_2,
    input  logic [XLEN-1:0]      inst_in,
    input  logic [XLEN-1:0]      pc_in,
    input  logic [XLEN-1:0]      snpc_in,
    output logic [XLEN-1:0]      pc,
    output logic [XLEN-1:0]      snpc,
    output logic [RF_ADDR_W-1:0] rs1_addr,
    output logic [RF_ADDR_W-1:0] rs2_addr,
    output logic [RF_ADDR_W-1:0] rd_addr,
    output logic [XLEN-1:0]      imm,
    output logic [3:0]           alu_op,
    output logic                 alu_a_sel,
    output logic                 alu_b_sel,
    output logic                 rf_wen,
    output logic [1:0]           wb_sel,
    output logic                 mem_r_en,
    output logic                 mem_w_en,
    output logic [2:0]           mem_funct3,
    output logic                 branch,
    output logic [2:0]           dnpc_mux_sel,
    output logic [11:0]          csr_addr,
    output logic [1:0]           csr_op,
    output logic                 ecall,
    output logic                 ebreak,
    output logic                 mret,
    output logic                 ill_inst,
    output logic [31:0]          dec_cnt
);

    localparam logic [6:0] c_op_lui    = 7'b0110111;
    localparam logic [6:0] c_op_auipc  = 7'b0010111;
    localparam logic [6:0] c_op_jal    = 7'b1101111;
    localparam logic [6:0] c_op_jalr   = 7'b1100111;
    localparam logic [6:0] c_op_branch = 7'b1100011;
    localparam logic [6:0] c_op_load   = 7'b0000011;
    localparam logic [6:0] c_op_store  = 7'b0100011;
    localparam logic [6:0] c_op_opimm  = 7'b0010011;
    localparam logic [6:0] c_op_op     = 7'b0110011;
    localparam logic [6:0] c_op_system = 7'b1110011;

    localparam logic [3:0] c_alu_add  = 4'd0;
    localparam logic [3:0] c_alu_sub  = 4'd1;
    localparam logic [3:0] c_alu_sll  = 4'd2;
    localparam logic [3:0] c_alu_slt  = 4'd3;
    localparam logic [3:0] c_alu_sltu = 4'd4;
    localparam logic [3:0] c_alu_xor  = 4'd5;
    localparam logic [3:0] c_alu_srl  = 4'd6;
    localparam logic [3:0] c_alu_sra  = 4'd7;
    localparam logic [3:0] c_alu_or   = 4'd8;
    localparam logic [3:0] c_alu_and  = 4'd9;
    localparam logic [3:0] c_alu_passb = 4'd10;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_FULL = 1'b1
    } state_t;

    state_t r_state;

    logic [6:0]      w_opcode;
    logic [2:0]      w_funct3;
    logic [6:0]      w_funct7;
    logic [XLEN-1:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;

    logic            w_legal;
    logic [XLEN-1:0] w_imm;
    logic [3:0]      w_alu_op;
    logic            w_alu_a_sel, w_alu_b_sel, w_rf_wen;
    logic [1:0]      w_wb_sel;
    logic            w_mem_r_en, w_mem_w_en, w_branch;
    logic [2:0]      w_mem_funct3, w_dnpc_mux_sel;
    logic [1:0]      w_csr_op;
    logic            w_ecall, w_ebreak, w_mret;
    logic            w_accept, w_handoff;

    assign w_opcode = inst_in[6:0];
    assign w_funct3 = inst_in[14:12];
    assign w_funct7 = inst_in[31:25];

    assign w_imm_i = {{(XLEN-12){inst_in[31]}}, inst_in[31:20]};
    assign w_imm_s = {{(XLEN-12){inst_in[31]}}, inst_in[31:25], inst_in[11:7]};
    assign w_imm_b = {{(XLEN-12){inst_in[31]}}, inst_in[7], inst_in[30:25], inst_in[11:8], 1'b0};
    assign w_imm_u = {{(XLEN-32){inst_in[31]}}, inst_in[31:12], 12'b0};
    assign w_imm_j = {{(XLEN-20){inst_in[31]}}, inst_in[19:12], inst_in[20], inst_in[30:21], 1'b0};

    assign ready_1   = (r_state == S_IDLE);
    assign valid_2   = (r_state == S_FULL);
    assign w_accept  = valid_1 && ready_1;
    assign w_handoff = valid_2 && ready_2;

    // Combinational decode of the incoming instruction; registered on accept.
    always_comb begin
        w_legal        = 1'b1;
        w_imm          = '0;
        w_alu_op       = c_alu_add;
        w_alu_a_sel    = 1'b0;
        w_alu_b_sel    = 1'b0;
        w_rf_wen       = 1'b0;
        w_wb_sel       = 2'd0;
        w_mem_r_en     = 1'b0;
        w_mem_w_en     = 1'b0;
        w_mem_funct3   = 3'd0;
        w_branch       = 1'b0;
        w_dnpc_mux_sel = 3'd0;
        w_csr_op       = 2'd0;
        w_ecall        = 1'b0;
        w_ebreak       = 1'b0;
        w_mret         = 1'b0;
        case (w_opcode)
            c_op_lui: begin
                w_imm = w_imm_u; w_alu_op = c_alu_passb; w_alu_b_sel = 1'b1; w_rf_wen = 1'b1;
            end
            c_op_auipc: begin
                w_imm = w_imm_u; w_alu_a_sel = 1'b1; w_alu_b_sel = 1'b1; w_rf_wen = 1'b1;
            end
            c_op_jal: begin
                w_imm = w_imm_j; w_dnpc_mux_sel = 3'd1; w_wb_sel = 2'd2; w_rf_wen = 1'b1;
            end
            c_op_jalr: begin
                w_legal = (w_funct3 == 3'b000);
                w_imm = w_imm_i; w_alu_b_sel = 1'b1; w_dnpc_mux_sel = 3'd2;
                w_wb_sel = 2'd2; w_rf_wen = 1'b1;
            end
            c_op_branch: begin
                w_legal = (w_funct3[2:1] != 2'b01);
                w_imm = w_imm_b; w_branch = 1'b1; w_mem_funct3 = w_funct3;
                case (w_funct3[2:1])
                    2'b00:   w_alu_op = c_alu_sub;
                    2'b10:   w_alu_op = c_alu_slt;
                    default: w_alu_op = c_alu_sltu;
                endcase
            end
            c_op_load: begin
                w_legal = (w_funct3 != 3'b011) && (w_funct3 != 3'b110) && (w_funct3 != 3'b111);
                w_imm = w_imm_i; w_alu_b_sel = 1'b1; w_mem_r_en = 1'b1;
                w_mem_funct3 = w_funct3; w_wb_sel = 2'd1; w_rf_wen = 1'b1;
            end
            c_op_store: begin
                w_legal = (w_funct3[2] == 1'b0) && (w_funct3 != 3'b011);
                w_imm = w_imm_s; w_alu_b_sel = 1'b1; w_mem_w_en = 1'b1; w_mem_funct3 = w_funct3;
            end
            c_op_opimm, c_op_op: begin
                w_rf_wen = 1'b1;
                w_alu_b_sel = (w_opcode == c_op_opimm);
                w_imm = (w_opcode == c_op_opimm) ? w_imm_i : '0;
                case (w_funct3)
                    3'b000: w_alu_op = (w_opcode == c_op_op && inst_in[30]) ? c_alu_sub : c_alu_add;
                    3'b001: w_alu_op = c_alu_sll;
                    3'b010: w_alu_op = c_alu_slt;
                    3'b011: w_alu_op = c_alu_sltu;
                    3'b100: w_alu_op = c_alu_xor;
                    3'b101: w_alu_op = inst_in[30] ? c_alu_sra : c_alu_srl;
                    3'b110: w_alu_op = c_alu_or;
                    default: w_alu_op = c_alu_and;
                endcase
                // Only the shifts (op-imm) or add/sub/shifts (op) carry a funct7.
                if (w_opcode == c_op_op || w_funct3 == 3'b001 || w_funct3 == 3'b101) begin
                    w_legal = (w_funct7 == 7'b0) ||
                              (w_funct7 == 7'b0100000 && w_funct3 == 3'b101) ||
                              (w_funct7 == 7'b0100000 && w_funct3 == 3'b000 && w_opcode == c_op_op);
                end
            end
            c_op_system: begin
                case (w_funct3)
                    3'b000: begin
                        w_ecall  = (inst_in == 32'h0000_0073);
                        w_ebreak = (inst_in == 32'h0010_0073);
                        w_mret   = (inst_in == 32'h3020_0073);
                        w_legal  = w_ecall || w_ebreak || w_mret;
                        w_dnpc_mux_sel = w_ecall ? 3'd3 : (w_mret ? 3'd4 : 3'd0);
                    end
                    3'b001: begin w_csr_op = 2'd1; w_wb_sel = 2'd3; w_rf_wen = 1'b1; end
                    3'b010: begin w_csr_op = 2'd2; w_wb_sel = 2'd3; w_rf_wen = 1'b1; end
                    default: w_legal = 1'b0;
                endcase
            end
            default: w_legal = 1'b0;
        endcase
        // Writes to x0 are architecturally discarded.
        if (inst_in[11:7] == 5'd0) begin
            w_rf_wen = 1'b0;
        end
        if (!w_legal) begin
            w_rf_wen   = 1'b0;
            w_mem_r_en = 1'b0;
            w_mem_w_en = 1'b0;
            w_csr_op   = 2'd0;
            w_branch   = 1'b0;
            w_ecall    = 1'b0;
            w_ebreak   = 1'b0;
            w_mret     = 1'b0;
`ifdef YSYX_23060075_ILLEGAL_TRAP_EN
            w_dnpc_mux_sel = 3'd3;
`else
            w_dnpc_mux_sel = 3'd0;
`endif
        end
    end

    // Handshake FSM: IDLE accepts from IFU, FULL offers the bundle downstream.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else if (r_state == S_IDLE) begin
            if (w_accept) r_state <= S_FULL;
        end else begin
            if (w_handoff) r_state <= S_IDLE;
        end
    end

    // Bundle register: captured on accept, held through backpressure and IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= '0; snpc <= '0; rs1_addr <= '0; rs2_addr <= '0; rd_addr <= '0;
            imm <= '0; alu_op <= '0; alu_a_sel <= 1'b0; alu_b_sel <= 1'b0;
            rf_wen <= 1'b0; wb_sel <= '0; mem_r_en <= 1'b0; mem_w_en <= 1'b0;
            mem_funct3 <= '0; branch <= 1'b0; dnpc_mux_sel <= '0; csr_addr <= '0;
            csr_op <= '0; ecall <= 1'b0; ebreak <= 1'b0; mret <= 1'b0;
        end else if (w_accept) begin
            pc           <= pc_in;
            snpc         <= snpc_in;
            rs1_addr     <= inst_in[15 +: RF_ADDR_W];
            rs2_addr     <= inst_in[20 +: RF_ADDR_W];
            rd_addr      <= inst_in[7 +: RF_ADDR_W];
            imm          <= w_imm;
            alu_op       <= w_alu_op;
            alu_a_sel    <= w_alu_a_sel;
            alu_b_sel    <= w_alu_b_sel;
            rf_wen       <= w_rf_wen;
            wb_sel       <= w_wb_sel;
            mem_r_en     <= w_mem_r_en;
            mem_w_en     <= w_mem_w_en;
            mem_funct3   <= w_mem_funct3;
            branch       <= w_branch;
            dnpc_mux_sel <= w_dnpc_mux_sel;
            csr_addr     <= inst_in[31:20];
            csr_op       <= w_csr_op;
            ecall        <= w_ecall;
            ebreak       <= w_ebreak;
            mret         <= w_mret;
        end
    end

`ifdef YSYX_23060075_ILLEGAL_TRAP_EN
    // Illegal-instruction flag captured alongside the bundle.
    always_ff @(posedge clk) begin
        if (rst) begin
            ill_inst <= 1'b0;
        end else if (w_accept) begin
            ill_inst <= !w_legal;
        end
    end
`else
    assign ill_inst = 1'b0;
`endif

    // Count bundles handed downstream; wraps naturally at 2^32.
    always_ff @(posedge clk) begin
        if (rst) begin
            dec_cnt <= '0;
        end else if (w_handoff) begin
            dec_cnt <= dec_cnt + 32'd1;
        end
    end

endmodule

`default_nettype wire

// File: doc/ysyx_23060075_idu.md
# ysyx_23060075_idu

Instruction decode stage of the ysyx_23060075 multi-cycle core, directly downstream of the IFU. It accepts a fetched instruction with its pc/snpc over a valid/ready handshake and registers them. It decodes RV32I plus the Zicsr/privileged subset (ecall, ebreak, mret, csrrw/csrrs) into register addresses, a sign-extended immediate and control selects for the EXU/LSU/WBU. It then presents the registered result downstream over a second valid/ready handshake.

## Interface
Parameters:
- XLEN, 32, data/address width.
- RF_ADDR_W, 5, register-file index width.

Ports:
- clk  in  1  clock, all state updates on posedge.
- rst  in  1  reset; synchronous, active-high.
- valid_1  in  1  upstream (IFU) has an instruction.
- ready_1  out  1  IDU can accept.
- valid_2  out  1  decoded bundle valid.
- ready_2  in  1  downstream accepts.
- inst_in / pc_in / snpc_in  in  XLEN each  fetched instruction, its pc, pc+4.
- pc / snpc  out  XLEN each  registered copies.
- rs1_addr / rs2_addr / rd_addr  out  RF_ADDR_W each  inst[19:15] / [24:20] / [11:7].
- imm  out  XLEN  sign-extended immediate.
- alu_op  out  4  0 add, 1 sub, 2 sll, 3 slt, 4 sltu, 5 xor, 6 srl, 7 sra, 8 or, 9 and, 10 pass-B.
- alu_a_sel  out  1  0 rs1, 1 pc.
- alu_b_sel  out  1  0 rs2, 1 imm.
- rf_wen  out  1  register write enable; forced 0 when rd_addr==0.
- wb_sel  out  2  0 alu, 1 mem, 2 snpc, 3 csr.
- mem_r_en / mem_w_en  out  1 each  load / store.
- mem_funct3  out  3  inst[14:12] for loads and stores.
- branch  out  1  conditional branch; funct3 via mem_funct3.
- dnpc_mux_sel  out  3  0 snpc, 1 pc_imm, 2 alu_result, 3 mtvec, 4 mepc.
- csr_addr  out  12  inst[31:20].
- csr_op  out  2  0 none, 1 rw, 2 rs.
- ecall / ebreak / mret  out  1 each  decoded system instruction.
- ill_inst  out  1  illegal instruction (macro-dependent).
- dec_cnt  out  32  count of bundles handed downstream.

## Operation
- Two-state FSM:
  - IDLE: ready_1=1, valid_2=0.
  - FULL: ready_1=0, valid_2=1.
- IDLE -> FULL when valid_1&&ready_1. On that edge, inst/pc/snpc are captured and all decoded outputs are registered from the captured values.
- FULL -> IDLE when valid_2&&ready_2. On that edge, dec_cnt increments.
- In IDLE, outputs hold the last bundle's values (stable, not cleared).
- Immediate formats (all sign-extended from inst[31]):
  - I: load, op-imm, jalr.
  - S: store.
  - B: branch, bit0=0.
  - U: lui, auipc, low 12 bits zero.
  - J: jal, bit0=0.
  - System instructions: imm = 0.
- Decode specifics:
  - lui: alu_a_sel=don't-care, alu_op=10, alu_b_sel=1.
  - auipc: alu_a_sel=1, alu_op=0, alu_b_sel=1.
  - jal: dnpc_mux_sel=1, wb_sel=2.
  - jalr: alu_op=0, alu_b_sel=1, dnpc_mux_sel=2, wb_sel=2.
  - branch: alu_op=sub/slt/sltu by funct3, dnpc_mux_sel=0 (EXU selects pc_imm when taken).
  - ecall: dnpc_mux_sel=3.
  - mret: dnpc_mux_sel=4.
  - ebreak: flag only.
  - Shift-immediate: inst[30] selects srl vs sra.
- dec_cnt wraps from 0xFFFFFFFF to 0.

## Timing
- Reset values: FSM in IDLE, ready_1=1, valid_2=0, every other output 0, dec_cnt=0.
- Latency: accept at edge N gives valid_2=1 from edge N+1 on.
- Throughput: at most one instruction per 2 cycles.
- ready_1 and valid_2 are never both 1, so there is no simultaneous in/out transfer.
- Backpressure: while valid_2=1 and ready_2=0, every output holds stable.
- valid_1 while FULL is ignored; the IFU holds its data.
- rst in FULL: the next edge returns to IDLE with reset values. The bundle is dropped and dec_cnt is cleared.
- rst has priority over both handshakes on the same edge.

## Configuration
- YSYX_23060075_ILLEGAL_TRAP_EN defined: an opcode/funct combination outside the supported set sets ill_inst=1 and dnpc_mux_sel=3. rf_wen, mem_r_en, mem_w_en and csr_op are forced 0 for that instruction.
- Not defined: ill_inst is tied 0. An unsupported instruction decodes as a nop: all enables 0, dnpc_mux_sel=0.

## Test plan
- Reset, then addi x1,x0,5 (0x00500093) -> one cycle after accept:
  - valid_2=1, rd_addr=1, rs1_addr=0, imm=0x00000005.
  - alu_op=0, alu_b_sel=1, rf_wen=1, wb_sel=0.
- lw x2,-4(x1) (0xFFC0A103) -> imm=0xFFFFFFFC, mem_r_en=1, mem_funct3=3'b010, wb_sel=1, rf_wen=1.
- jal x1,8 (0x008000EF) at pc=0x80000000 -> imm=0x00000008, dnpc_mux_sel=1, wb_sel=2, snpc=0x80000004.
- Backpressure: after accept of 0x00500093, hold ready_2=0 for 3 cycles -> valid_2=1, ready_1=0 and all outputs stable. Raise ready_2 -> next edge ready_1=1, valid_2=0, dec_cnt=1.
- Illegal 0x00000000:
  - With macro: ill_inst=1, dnpc_mux_sel=3, rf_wen=0.
  - Without macro: ill_inst=0, all enables 0, dnpc_mux_sel=0.
- Assert rst while in FULL -> next edge valid_2=0, ready_1=1, dec_cnt=0, imm=0.
